uart_tx_feeder: RTL and testbench

Byte buffer and pacing stage placed directly upstream of the UART transmitter. It accepts bytes from the CPU or bus side into a circular FIFO and hands them to the transmitter one at a time: a one-cycle write strobe plus a byte that is held stable. The transmitter exports no busy flag, so this block spaces its strobes by a fixed, parameterised frame gap; no strobe is ever issued while a frame could still be in flight.

---
 rtl/uart_tx_feeder.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter that has no busy flag: bytes are
// released one at a time as single-cycle strobes spaced by a fixed frame gap.
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 10000,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_n_i,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_dat_i,
    input  logic          clr_ovf_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o,
    output logic          overflow_o,
    output logic          idle_o,
    output logic          uart_wr_o,
    output logic [7:0]    uart_dat_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_level_nxt;
    logic            r_ovf;
    logic            w_ovf_nxt;
    logic            r_uart_wr;
    logic            w_uart_wr_nxt;
    logic [7:0]      r_uart_dat;
    logic [7:0]      w_uart_dat_nxt;
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_drop;
    logic            w_pop;

    // Occupancy flags come straight from the level register, so a push
    // while full is judged on the pre-edge level even if a pop coincides.
    assign w_full    = (r_level == DEPTH_L);
    assign w_empty   = (r_level == LW'(0));
    assign w_push_ok = wr_en_i & ~w_full;
    assign w_drop    = wr_en_i & w_full;

    // Pacing FSM next-state, pop decision and transmitter strobe/data.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pop          = 1'b0;
        w_uart_wr_nxt  = 1'b0;
        w_uart_dat_nxt = r_uart_dat;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_uart_wr_nxt  = 1'b1;
                    w_uart_dat_nxt = r_mem[r_rd_ptr];
                    w_cnt_nxt      = GAP_LOAD;
                    w_state_nxt    = ST_GAP;
                end else begin
                    w_cnt_nxt      = CW'(0);
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_GAP: begin
                // Leaving on cnt==1 puts the next pop exactly GAP_CYCLES
                // edges after the previous one.
                if (r_cnt <= CW'(1)) begin
                    w_cnt_nxt   = CW'(0);
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_cnt_nxt   = CW'(0);
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Level and sticky overflow next values; a dropped push beats a clear.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push_ok, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
        if (w_drop) begin
            w_ovf_nxt = 1'b1;
        end else if (clr_ovf_i) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end
    end

    // FSM state and gap counter register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= CW'(0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FIFO pointers, level, overflow flag and transmitter-facing outputs.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_wr_ptr   <= PW'(0);
            r_rd_ptr   <= PW'(0);
            r_level    <= LW'(0);
            r_ovf      <= 1'b0;
            r_uart_wr  <= 1'b0;
            r_uart_dat <= 8'h00;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level    <= w_level_nxt;
            r_ovf      <= w_ovf_nxt;
            r_uart_wr  <= w_uart_wr_nxt;
            r_uart_dat <= w_uart_dat_nxt;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge sys_clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_dat_i;
        end
    end

    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign level_o    = r_level;
    assign overflow_o = r_ovf;
    assign idle_o     = w_empty & (r_state == ST_IDLE);
    assign uart_wr_o  = r_uart_wr;
    assign uart_dat_o = r_uart_dat;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder (DEPTH=4, GAP_CYCLES=8) using a
// queue-and-timestamp reference model of the buffer and pacing rules.
module tb_uart_tx_feeder;

    localparam int DEPTH = 4;
    localparam int GAP   = 8;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_dat;
    logic          clr_ovf;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          ovf;
    logic          idle;
    logic          uwr;
    logic [7:0]    udat;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue contents plus the edge index of the last strobe.
    logic [7:0] m_q[$];
    int         m_cyc;
    int         m_last;
    logic       m_wr;
    logic [7:0] m_dat;
    logic       m_ovf;

    uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .wr_en_i     (wr_en),
        .wr_dat_i    (wr_dat),
        .clr_ovf_i   (clr_ovf),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .overflow_o  (ovf),
        .idle_o      (idle),
        .uart_wr_o   (uwr),
        .uart_dat_o  (udat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        m_cyc  = 0;
        m_last = -1000;
        m_wr   = 1'b0;
        m_dat  = 8'h00;
        m_ovf  = 1'b0;
    endtask

    function automatic logic m_idle();
        return (m_q.size() == 0) && (m_cyc >= m_last + GAP - 1);
    endfunction

    // One clock edge of the spec's rules: pop if a byte waits and the gap
    // since the last strobe has elapsed; push if there was room before the edge.
    task automatic model_edge(input logic we, input logic [7:0] d, input logic clr);
        int pre;
        pre = m_q.size();
        m_cyc++;
        if (pre > 0 && m_cyc >= m_last + GAP) begin
            m_dat  = m_q.pop_front();
            m_wr   = 1'b1;
            m_last = m_cyc;
        end else begin
            m_wr = 1'b0;
        end
        if (we && pre >= DEPTH) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (we && pre < DEPTH) m_q.push_back(d);
    endtask

    task automatic tick(input logic we, input logic [7:0] d, input logic clr);
        wr_en   = we;
        wr_dat  = d;
        clr_ovf = clr;
        @(posedge clk);
        model_edge(we, d, clr);
        @(negedge clk);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (m_q.size() == 0 && m_idle()) break;
            tick(1'b0, 8'h00, 1'b0);
        end
        n_vec++;
        if (idle !== 1'b1 || !m_idle()) begin
            n_err++;
            $display("FAIL drain_idle: got %b expected 1", idle);
        end
    endtask

    task automatic test_reset();
        n_vec++; if (uwr !== 1'b0)   begin n_err++; $display("FAIL rst_wr: got %b expected 0", uwr); end
        n_vec++; if (udat !== 8'h00) begin n_err++; $display("FAIL rst_dat: got %h expected 00", udat); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", level); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b expected 1", empty); end
        n_vec++; if (full !== 1'b0)  begin n_err++; $display("FAIL rst_full: got %b expected 0", full); end
        n_vec++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        n_vec++; if (idle !== 1'b1)  begin n_err++; $display("FAIL rst_idle: got %b expected 1", idle); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'h4D, 1'b0);
        n_vec++; if (uwr !== 1'b1 || udat !== 8'h3C) begin n_err++; $display("FAIL pre_async_strobe: got %b/%h expected 1/3c", uwr, udat); end
        // Asynchronous assertion between edges must clear outputs at once.
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (uwr !== 1'b0)   begin n_err++; $display("FAIL async_wr: got %b expected 0", uwr); end
        n_vec++; if (udat !== 8'h00) begin n_err++; $display("FAIL async_dat: got %h expected 00", udat); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL async_level: got %0d expected 0", level); end
        n_vec++; if (idle !== 1'b1 || empty !== 1'b1) begin n_err++; $display("FAIL async_idle: got %b/%b expected 1/1", idle, empty); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drain();
        tick(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_vec++; if (uwr !== (k == 1)) begin n_err++; $display("FAIL single_wr[%0d]: got %b expected %b", k, uwr, (k == 1)); end
            n_vec++; if (udat !== 8'hA5)   begin n_err++; $display("FAIL single_dat[%0d]: got %h expected a5", k, udat); end
            n_vec++; if (idle !== (k >= 8)) begin n_err++; $display("FAIL single_idle[%0d]: got %b expected %b", k, idle, (k >= 8)); end
        end
    endtask

    task automatic test_back_to_back();
        int t_seen[$];
        logic [7:0] d_seen[$];
        int peak;
        int exp_t[4] = '{1, 9, 17, 25};
        peak = 0;
        drain();
        for (int e = 0; e < 35; e++) begin
            if (e < 4) tick(1'b1, 8'(e + 1), 1'b0);
            else tick(1'b0, 8'h00, 1'b0);
            if (uwr === 1'b1) begin t_seen.push_back(e); d_seen.push_back(udat); end
            if (int'(level) > peak) peak = int'(level);
            n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL burst_ovf[%0d]: got %b expected 0", e, ovf); end
        end
        n_vec++; if (t_seen.size() != 4) begin n_err++; $display("FAIL burst_count: got %0d expected 4", t_seen.size()); end
        for (int i = 0; i < 4 && i < t_seen.size(); i++) begin
            n_vec++; if (t_seen[i] != exp_t[i]) begin n_err++; $display("FAIL burst_time[%0d]: got %0d expected %0d", i, t_seen[i], exp_t[i]); end
            n_vec++; if (d_seen[i] !== 8'(i + 1)) begin n_err++; $display("FAIL burst_data[%0d]: got %h expected %h", i, d_seen[i], 8'(i + 1)); end
        end
        n_vec++; if (peak != 3) begin n_err++; $display("FAIL burst_peak: got %0d expected 3", peak); end
    endtask

    task automatic test_overflow();
        drain();
        tick(1'b1, 8'h55, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        n_vec++; if (uwr !== 1'b1 || udat !== 8'h55) begin n_err++; $display("FAIL ovf_first: got %b/%h expected 1/55", uwr, udat); end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'(8'hA0 + i), 1'b0);
            n_vec++; if (full !== (i >= 3)) begin n_err++; $display("FAIL ovf_full[%0d]: got %b expected %b", i, full, (i >= 3)); end
            n_vec++; if (ovf !== (i >= 4))  begin n_err++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, ovf, (i >= 4)); end
            n_vec++; if (level !== 3'((i >= 3) ? 4 : i + 1)) begin n_err++; $display("FAIL ovf_level[%0d]: got %0d expected %0d", i, level, (i >= 3) ? 4 : i + 1); end
        end
        tick(1'b0, 8'h00, 1'b1);
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        // Push while full on the same edge as a pop: push is dropped.
        tick(1'b1, 8'hEE, 1'b0);
        n_vec++; if (uwr !== 1'b1 || udat !== 8'hA0) begin n_err++; $display("FAIL ovf_pop: got %b/%h expected 1/a0", uwr, udat); end
        n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL ovf_pop_level: got %0d expected 3", level); end
        n_vec++; if (ovf !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL ovf_pop_flag: got %b/%b expected 1/0", ovf, full); end
        tick(1'b0, 8'h00, 1'b1);
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear2: got %b expected 0", ovf); end
    endtask

    task automatic test_wrap();
        logic [7:0] rx[$];
        int pushed;
        logic we;
        pushed = 0;
        drain();
        for (int c = 0; c < 200 && rx.size() < 10; c++) begin
            we = (pushed < 10) && (full === 1'b0);
            tick(we, 8'(8'h10 + pushed), 1'b0);
            if (we) pushed++;
            if (uwr === 1'b1) rx.push_back(udat);
            n_vec++; if (level > 3'd4) begin n_err++; $display("FAIL wrap_level[%0d]: got %0d expected <=4", c, level); end
        end
        n_vec++; if (rx.size() != 10) begin n_err++; $display("FAIL wrap_count: got %0d expected 10", rx.size()); end
        for (int i = 0; i < rx.size(); i++) begin
            n_vec++; if (rx[i] !== 8'(8'h10 + i)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rx[i], 8'(8'h10 + i)); end
        end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_reset_midgap();
        drain();
        tick(1'b1, 8'h61, 1'b0);
        tick(1'b1, 8'h62, 1'b0);
        tick(1'b1, 8'h63, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL midgap_pre_level: got %0d expected 2", level); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (level !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL midgap_level: got %0d expected 0", level); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_vec++; if (uwr !== 1'b0 || level !== 3'd0) begin n_err++; $display("FAIL midgap_quiet[%0d]: got %b/%0d expected 0/0", k, uwr, level); end
        end
        tick(1'b1, 8'h7E, 1'b0);
        n_vec++; if (uwr !== 1'b0) begin n_err++; $display("FAIL midgap_early: got %b expected 0", uwr); end
        tick(1'b0, 8'h00, 1'b0);
        n_vec++; if (uwr !== 1'b1 || udat !== 8'h7E) begin n_err++; $display("FAIL midgap_restart: got %b/%h expected 1/7e", uwr, udat); end
    endtask

    task automatic test_random();
        int prob;
        logic we;
        logic clr;
        prob = 30;
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) prob = $urandom_range(5, 70);
            we  = ($urandom_range(0, 99) < prob);
            clr = ($urandom_range(0, 99) < 8);
            tick(we, 8'($urandom_range(0, 255)), clr);
            n_vec++; if (uwr !== m_wr)   begin n_err++; $display("FAIL rnd_wr[%0d]: got %b expected %b", c, uwr, m_wr); end
            n_vec++; if (udat !== m_dat) begin n_err++; $display("FAIL rnd_dat[%0d]: got %h expected %h", c, udat, m_dat); end
            n_vec++; if (level !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", c, level, m_q.size()); end
            n_vec++; if (full !== (m_q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d]: got %b expected %b", c, full, (m_q.size() == DEPTH)); end
            n_vec++; if (empty !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b expected %b", c, empty, (m_q.size() == 0)); end
            n_vec++; if (ovf !== m_ovf)  begin n_err++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", c, ovf, m_ovf); end
            n_vec++; if (idle !== m_idle()) begin n_err++; $display("FAIL rnd_idle[%0d]: got %b expected %b", c, idle, m_idle()); end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_dat  = 8'h00;
        clr_ovf = 1'b0;
        model_reset();
        #23;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_midgap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
